// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the parallel-to-serial frame generator.
package bit_serializer_pkg;

    localparam int BIT_SERIALIZER_DEFAULT_WIDTH = 32'sd8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/bit_serializer.sv
// Parallel word to serial bit-stream converter with ready/valid load handshake.
// Define BIT_SERIALIZER_LSB_FIRST_EN to emit load_data[0] first instead of the MSB.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = BIT_SERIALIZER_DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         load_data,
    input  logic                     load_valid,
    output logic                     load_ready,
    output logic                     data_out,
    output logic                     out_valid,
    output logic                     frame_done,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_e           state_r;
    state_e           state_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_s;
    logic [IDX_W-1:0] bit_idx_r;
    logic [IDX_W-1:0] bit_idx_s;
    logic [IDX_W-1:0] bit_idx_inc_s;
    logic             data_out_r;
    logic             data_out_s;
    logic             out_valid_r;
    logic             out_valid_s;
    logic             frame_done_r;
    logic             frame_done_s;
    logic             load_ready_s;
    logic             accept_s;
    logic             head_load_s;
    logic [WIDTH-1:0] tail_load_s;
    logic             head_reg_s;
    logic [WIDTH-1:0] tail_reg_s;

    // The shift register holds only the bits still to be emitted after the one on data_out.
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
    assign head_load_s = load_data[0];
    assign tail_load_s = load_data >> 1'b1;
    assign head_reg_s  = shreg_r[0];
    assign tail_reg_s  = shreg_r >> 1'b1;
`else
    assign head_load_s = load_data[WIDTH-1];
    assign tail_load_s = load_data << 1'b1;
    assign head_reg_s  = shreg_r[WIDTH-1];
    assign tail_reg_s  = shreg_r << 1'b1;
`endif

    assign bit_idx_inc_s = bit_idx_r + IDX_W'(1);

    // Ready in IDLE or on the last bit of a frame, never while reset is asserted.
    always_comb begin
        load_ready_s = 1'b0;
        if (!reset) begin
            load_ready_s = 1'b0;
        end else if (state_r == IDLE) begin
            load_ready_s = 1'b1;
        end else if (bit_idx_r == LAST_IDX) begin
            load_ready_s = 1'b1;
        end else begin
            load_ready_s = 1'b0;
        end
    end

    assign accept_s = load_valid & load_ready_s;

    // Next-state: load a new frame, continue shifting, or fall back to the idle filler.
    always_comb begin
        state_s      = IDLE;
        shreg_s      = '0;
        bit_idx_s    = '0;
        data_out_s   = 1'b0;
        out_valid_s  = 1'b0;
        frame_done_s = 1'b0;
        if (accept_s) begin
            state_s      = SHIFT;
            shreg_s      = tail_load_s;
            bit_idx_s    = '0;
            data_out_s   = head_load_s;
            out_valid_s  = 1'b1;
            frame_done_s = 1'b0;
        end else if ((state_r == SHIFT) && (bit_idx_r != LAST_IDX)) begin
            state_s      = SHIFT;
            shreg_s      = tail_reg_s;
            bit_idx_s    = bit_idx_inc_s;
            data_out_s   = head_reg_s;
            out_valid_s  = 1'b1;
            frame_done_s = (bit_idx_inc_s == LAST_IDX);
        end else begin
            state_s      = IDLE;
            shreg_s      = '0;
            bit_idx_s    = '0;
            data_out_s   = 1'b0;
            out_valid_s  = 1'b0;
            frame_done_s = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            shreg_r      <= '0;
            bit_idx_r    <= '0;
            data_out_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            shreg_r      <= shreg_s;
            bit_idx_r    <= bit_idx_s;
            data_out_r   <= data_out_s;
            out_valid_r  <= out_valid_s;
            frame_done_r <= frame_done_s;
        end
    end

    assign load_ready = load_ready_s;
    assign data_out   = data_out_r;
    assign out_valid  = out_valid_r;
    assign frame_done = frame_done_r;
    assign bit_idx    = bit_idx_r;

endmodule

// File: tb/tb_bit_serializer.sv
// Randomized bench for bit_serializer: a queue of pending frame bits is the reference model.
module tb_bit_serializer;

    localparam int W  = 8;
    localparam int IW = $clog2(W);

`ifdef BIT_SERIALIZER_LSB_FIRST_EN
    localparam logic [7:0] WORD_A = 8'h2B;
`else
    localparam logic [7:0] WORD_A = 8'hD4;
`endif

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic [W-1:0]  load_data  = '0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic          data_out;
    logic          out_valid;
    logic          frame_done;
    logic [IW-1:0] bit_idx;

    bit_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .bit_idx    (bit_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        int   idx;
    } ent_t;

    // Bits still to appear on data_out; the head is the bit shown this cycle.
    ent_t q[$];
    int   checks = 0;
    int   passed = 0;
    bit   cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic model_ready();
        return reset && (q.size() <= 1);
    endfunction

    always @(posedge clk) begin
        logic acc;
        ent_t e;
        acc = load_valid && model_ready();
        if (!reset) begin
            q.delete();
        end else begin
            if (q.size() > 0) void'(q.pop_front());
            if (acc) begin
                for (int i = 0; i < W; i++) begin
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
                    e.b = load_data[i];
`else
                    e.b = load_data[W-1-i];
`endif
                    e.idx = i;
                    q.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic ev, eb, ed;
        int   ei;
        if (cmp_en) begin
            if (q.size() > 0) begin
                ev = 1'b1; eb = q[0].b; ei = q[0].idx; ed = (ei == W-1);
            end else begin
                ev = 1'b0; eb = 1'b0; ei = 0; ed = 1'b0;
            end
            check("out_valid",  32'(out_valid),  32'(ev));
            check("data_out",   32'(data_out),   32'(eb));
            check("bit_idx",    32'(bit_idx),    ei);
            check("frame_done", 32'(frame_done), 32'(ed));
            check("load_ready", 32'(load_ready), 32'(model_ready()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  stream;
        logic [7:0]  vmask;
        logic [7:0]  dmask;
        logic [16:0] rmask;
        logic [15:0] vmask16;
        logic [15:0] dmask16;
        logic        found;

        repeat (3) step();
        cmp_en = 1'b1;
        sample();
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_data_out",   32'(data_out),   32'd0);
        check("rst_bit_idx",    32'(bit_idx),    32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd0);
        reset = 1'b1;
        step();

        // Single frame: serial stream, frame_done position, downstream 110101 match.
        load_data = WORD_A; load_valid = 1'b1;
        sample();
        check("single_ready_c0", 32'(load_ready), 32'd1);
        step();
        load_valid = 1'b0; load_data = W'($urandom);
        stream = '0; vmask = '0; dmask = '0;
        for (int c = 1; c <= 8; c++) begin
            sample();
            stream = {stream[6:0], data_out};
            vmask  = {vmask[6:0], out_valid};
            dmask  = {dmask[6:0], frame_done};
            step();
        end
        check("single_stream", 32'(stream), 32'hD4);
        check("single_valid",  32'(vmask),  32'hFF);
        check("single_done",   32'(dmask),  32'h01);
        found = 1'b0;
        for (int s = 0; s <= 2; s++)
            if (((stream >> s) & 8'h3F) == 8'h35) found = 1'b1;
        check("detector_match", 32'(found), 32'd1);

        // Gap: idle on cycle 9, new word offered on cycle 10, bits on 11..18.
        sample();
        check("gap_idle_valid", 32'(out_valid), 32'd0);
        check("gap_idle_data",  32'(data_out),  32'd0);
        step();
        load_data = W'($urandom); load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        vmask = '0;
        for (int c = 11; c <= 18; c++) begin
            sample();
            vmask = {vmask[6:0], out_valid};
            step();
        end
        check("gap_frame_valid", 32'(vmask), 32'hFF);
        repeat (2) step();

        // Back-to-back: load_valid held high across two frames.
        load_data = WORD_A; load_valid = 1'b1;
        rmask = '0; vmask16 = '0; dmask16 = '0;
        for (int c = 0; c <= 16; c++) begin
            sample();
            rmask[c] = load_ready;
            if (c >= 1) begin
                vmask16[c-1] = out_valid;
                dmask16[c-1] = frame_done;
            end
            if (c == 16) load_valid = 1'b0;
            step();
            if (c == 0) load_data = 8'hA5;
        end
        check("b2b_ready", 32'(rmask),   32'h10101);
        check("b2b_valid", 32'(vmask16), 32'hFFFF);
        check("b2b_done",  32'(dmask16), 32'h8080);
        repeat (2) step();

        // Reset asserted on cycle 4 of an all-ones frame.
        load_data = 8'hFF; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        sample();
        check("midrst_ready_low", 32'(load_ready), 32'd0);
        step();
        reset = 1'b1;
        sample();
        check("midrst_valid", 32'(out_valid),  32'd0);
        check("midrst_data",  32'(data_out),   32'd0);
        check("midrst_ready", 32'(load_ready), 32'd1);
        step();

        // Random traffic, including load_valid toggling mid-frame and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            load_valid = ($urandom_range(0, 2) != 0);
            load_data  = W'($urandom);
            reset      = ($urandom_range(0, 79) != 0);
            step();
        end
        reset = 1'b1; load_valid = 1'b0;
        repeat (12) step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port load_data, input, WIDTH bits: the parallel word to be serialized.
REQ-005 The block SHALL have port load_valid, input, 1 bit: load_data is valid this cycle.
REQ-006 The block SHALL have port load_ready, output, 1 bit: the block accepts a word this cycle.
REQ-007 The block SHALL have port data_out, output, 1 bit: the serial bit, fed to the downstream sequence detector's data_in.
REQ-008 The block SHALL have port out_valid, output, 1 bit: data_out carries a frame bit this cycle.
REQ-009 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse marking the last bit of a frame.
REQ-010 The block SHALL have port bit_idx, output, $clog2(WIDTH) bits: the index of the bit currently driven, counting from 0.

Function
REQ-011 The state machine SHALL have exactly two states.
- IDLE: no frame in progress.
- SHIFT: frame in progress.
REQ-012 load_ready SHALL equal 1 in IDLE, or in SHIFT when bit_idx==WIDTH-1, and 0 otherwise.
REQ-013 A word SHALL be accepted on a rising edge where load_valid and load_ready are both 1; the word is captured into an internal shift register and bit_idx is set to 0.
REQ-014 Latency: the first bit SHALL appear on data_out, with out_valid=1, in the cycle immediately after acceptance.
REQ-015 In SHIFT, the block SHALL emit exactly one bit per cycle for WIDTH consecutive cycles, with no stall; bit_idx increments by 1 each cycle.
REQ-016 Bit order SHALL be MSB first, load_data[WIDTH-1] first (default build).
REQ-017 frame_done SHALL be 1 exactly when out_valid=1 and bit_idx==WIDTH-1.
REQ-018 Back-to-back: if a word is accepted during the last-bit cycle, the next cycle SHALL carry bit 0 of the new word and the state stays SHIFT, giving zero idle gap.
REQ-019 If no word is accepted during the last-bit cycle, the state SHALL return to IDLE.
REQ-020 In IDLE, data_out, out_valid, frame_done and bit_idx SHALL all be 0; the idle filler bit is 0.
REQ-021 load_data and load_valid SHALL be ignored whenever load_ready=0.

Reset
REQ-022 While reset=0 at a clock edge, the state SHALL go to IDLE and the shift register and bit_idx SHALL clear to 0.
REQ-023 Reset values: data_out=0, out_valid=0, frame_done=0, bit_idx=0.
REQ-024 load_ready SHALL be 0 while reset=0.
REQ-025 Reset mid-frame SHALL abort the frame with no further frame bits emitted; the first cycle after release is IDLE with load_ready=1.

Configuration
REQ-026 Macro BIT_SERIALIZER_LSB_FIRST_EN SHALL select bit order.
- Defined: bits are emitted LSB first, load_data[0] first.
- Undefined: bits are emitted MSB first.
- All timing, handshake and frame_done behaviour is identical in both builds.

Structure
REQ-027 Package bit_serializer_pkg SHALL hold the state typedef (IDLE, SHIFT) and the constant BIT_SERIALIZER_DEFAULT_WIDTH=8.
REQ-028 The block SHALL be a single module with no sub-module; the counter and shift register are inline.

Verification
REQ-029 MSB-first, WIDTH=8: accept load_data=0xD4 at cycle 0 -> data_out=1,1,0,1,0,1,0,0 on cycles 1..8; out_valid=1 on cycles 1..8; frame_done=1 on cycle 8 only; a downstream 110101 detector reports a match.
REQ-030 Back-to-back: load_valid held at 1 with 0xD4 then 0xA5 -> 16 contiguous valid bits with no gap; frame_done=1 on cycles 8 and 16; load_ready=1 on cycles 0, 8 and 16 only.
REQ-031 Gap: a second word offered on cycle 10 -> IDLE outputs (all 0) on cycle 9; new frame bits on cycles 11..18.
REQ-032 Reset mid-frame: reset=0 at cycle 4 of a 0xFF frame -> out_valid=0 and data_out=0 from cycle 5; load_ready=1 on the first cycle after release.
REQ-033 BIT_SERIALIZER_LSB_FIRST_EN defined: accept 0x2B -> data_out=1,1,0,1,0,1,0,0.
REQ-034 Handshake ignore: toggle load_valid during SHIFT while bit_idx<7 -> output bit stream is unchanged.
